// File: rtl/latch_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// latch_wr_arbiter_if
//   Bundles the requester-side write/clear handshake and the latch-bank drive
//   signals of latch_wr_arbiter.
//
//   Requester side : req, addr, data, clr_req   -> arbiter
//                    gnt, ack, clr_ack, busy    <- arbiter
//   Latch-bank side: lat_en, lat_d, lat_rstn    <- arbiter
//
//   Modports:
//     master - requester/bank environment (drives requests, observes outputs)
//     slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface latch_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int W     = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  data;
  logic               clr_req;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               clr_ack;
  logic               busy;
  logic [DEPTH-1:0]   lat_en;
  logic [W-1:0]       lat_d;
  logic               lat_rstn;

  modport master (
    output req, addr, data, clr_req,
    input  gnt, ack, clr_ack, busy, lat_en, lat_d, lat_rstn
  );

  modport slave (
    input  req, addr, data, clr_req,
    output gnt, ack, clr_ack, busy, lat_en, lat_d, lat_rstn
  );
endinterface

// File: rtl/latch_wr_arbiter.sv
// ---------------------------------------------------------------------------
// latch_wr_arbiter
//   Shares one bank of DEPTH x W level-sensitive latches among NREQ
//   requesters. A winning write is driven as: data setup (1 cycle), one-hot
//   word enable (EN_CYC cycles), data hold (1 cycle, with ack). A bank clear
//   pulses lat_rstn low for one cycle with clr_ack. Clear beats any write.
//   All latch-facing outputs come straight from flops, so they are glitch-free.
//
//   Ports:
//     clk   - rising-edge clock
//     rstn  - synchronous, active-low reset
//     bus   - latch_wr_arbiter_if.slave (req/addr/data/clr_req in;
//             gnt/ack/clr_ack/busy/lat_en/lat_d/lat_rstn out)
//
//   Build option:
//     LATCH_WR_ARB_FIXED_PRIO_EN - when defined, lowest asserted req index
//     wins and the round-robin pointer is removed; otherwise round-robin.
//     Timing is identical in both builds.
// ---------------------------------------------------------------------------
module latch_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 8,
  parameter int W      = 8,
  parameter int EN_CYC = 2
) (
  input  logic                clk,
  input  logic                rstn,
  latch_wr_arbiter_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(EN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     lat_addr_q, lat_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              clr_ack_q, clr_ack_d;
  logic              busy_q, busy_d;
  logic [DEPTH-1:0]  lat_en_q, lat_en_d;
  logic [W-1:0]      lat_d_q, lat_d_d;
  logic              lat_rstn_q, lat_rstn_d;

`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
`endif

  // -------------------------------------------------------------------------
  // Winner selection (only consumed in IDLE)
  // -------------------------------------------------------------------------
  logic          found;
  logic [IW-1:0] pick;

`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end
`else
  // Scan from the pointer upward, wrapping at NREQ (NREQ need not be 2^n).
  int            idx;
  logic [IW-1:0] sel;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!found && bus.req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    clr_ack_d  = 1'b0;
    busy_d     = busy_q;
    lat_en_d   = lat_en_q;
    lat_d_d    = lat_d_q;
    lat_rstn_d = 1'b1;
`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
    win_d      = win_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d    = S_CLEAR;
          lat_rstn_d = 1'b0;
          clr_ack_d  = 1'b1;
          busy_d     = 1'b1;
        end else if (found) begin
          state_d    = S_SETUP;
          gnt_d      = NREQ'(1) << pick;
          lat_addr_d = bus.addr[int'(pick)*AW +: AW];
          lat_d_d    = bus.data[int'(pick)*W +: W];
          busy_d     = 1'b1;
`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
          win_d      = pick;
`endif
        end
      end

      // lat_d has been stable for one full cycle before the enable rises.
      S_SETUP: begin
        state_d  = S_ENABLE;
        lat_en_d = DEPTH'(1) << lat_addr_q;
        cnt_d    = CW'(EN_CYC - 1);
      end

      S_ENABLE: begin
        if (cnt_q == '0) begin
          state_d  = S_HOLD;
          lat_en_d = '0;
          ack_d    = gnt_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // lat_d is left untouched here so it is held past the enable fall.
      S_HOLD: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
`endif
      end

      S_CLEAR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rstn) begin
      state_q    <= S_IDLE;
      lat_addr_q <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      clr_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      lat_en_q   <= '0;
      lat_d_q    <= '0;
      lat_rstn_q <= 1'b1;
`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
      win_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      clr_ack_q  <= clr_ack_d;
      busy_q     <= busy_d;
      lat_en_q   <= lat_en_d;
      lat_d_q    <= lat_d_d;
      lat_rstn_q <= lat_rstn_d;
`ifndef LATCH_WR_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
      win_q      <= win_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.clr_ack  = clr_ack_q;
  assign bus.busy     = busy_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.lat_d    = lat_d_q;
  assign bus.lat_rstn = lat_rstn_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_latch_wr_arbiter
//   Directed bench for latch_wr_arbiter (default parameters). Inputs change
//   and outputs are sampled on the falling edge. Honours
//   LATCH_WR_ARB_FIXED_PRIO_EN for the expected winners.
// ---------------------------------------------------------------------------
module tb_latch_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DEPTH  = 8;
  localparam int W      = 8;
  localparam int EN_CYC = 2;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  latch_wr_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .W(W)) bus ();

  latch_wr_arbiter #(
    .NREQ(NREQ), .DEPTH(DEPTH), .W(W), .EN_CYC(EN_CYC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous spacing checks on the latch-facing outputs.
  logic prev_busy     = 1'b0;
  logic prev_lat_rstn = 1'b1;
  logic [DEPTH-1:0] prev_en = '0;

  always @(negedge clk) begin
    check("mon_en_onehot0", 64'($countones(bus.lat_en) <= 1), 64'(1));
    if (bus.ack != '0)
      check("mon_en_in_hold", 64'(bus.lat_en), 64'(0));
    if (bus.busy && !prev_busy)
      check("mon_en_in_setup", 64'(bus.lat_en), 64'(0));
    if (!bus.lat_rstn || !prev_lat_rstn)
      check("mon_en_near_clr", 64'(bus.lat_en), 64'(0));
    if (!bus.lat_rstn)
      check("mon_en_before_clr", 64'(prev_en), 64'(0));
    prev_busy     = bus.busy;
    prev_lat_rstn = bus.lat_rstn;
    prev_en       = bus.lat_en;
  end

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [2:0]       addr;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]  gnt_rr;
    logic [NREQ-1:0]  gnt_fp;
    logic [DEPTH-1:0] en;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.req = '0; bus.clr_req = 1'b0; bus.addr = '0; bus.data = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Entered and left on a falling edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    logic [NREQ-1:0] eg;
    logic [W-1:0]    ed;
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
    eg = v.gnt_fp;
`else
    eg = v.gnt_rr;
`endif
    ed = '0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) ed = v.data[i*W +: W];
    bus.req  = v.req;
    bus.addr = {NREQ{v.addr}};
    bus.data = v.data;
    @(negedge clk);
    check("vec_setup_gnt",  64'(bus.gnt),    64'(eg));
    check("vec_setup_d",    64'(bus.lat_d),  64'(ed));
    check("vec_setup_en",   64'(bus.lat_en), 64'(0));
    check("vec_setup_busy", 64'(bus.busy),   64'(1));
    for (int c = 0; c < EN_CYC; c++) begin
      @(negedge clk);
      check("vec_enable_en",  64'(bus.lat_en), 64'(v.en));
      check("vec_enable_ack", 64'(bus.ack),    64'(0));
    end
    @(negedge clk);
    check("vec_hold_ack", 64'(bus.ack),    64'(eg));
    check("vec_hold_en",  64'(bus.lat_en), 64'(0));
    check("vec_hold_d",   64'(bus.lat_d),  64'(ed));
    bus.req = '0;
    @(negedge clk);
    check("vec_idle_busy", 64'(bus.busy), 64'(0));
    check("vec_idle_gnt",  64'(bus.gnt),  64'(0));
    check("vec_idle_ack",  64'(bus.ack),  64'(0));
  endtask

  initial begin
    logic [NREQ-1:0] order_rr [5];
    logic [NREQ-1:0] exp_g;
    logic            seen;
    int              n;

    vecs[0] = '{4'b0010, 3'd3, 32'h0000_A500, 4'b0010, 4'b0010, 8'h08};
    vecs[1] = '{4'b1111, 3'd0, 32'h4433_2211, 4'b0100, 4'b0001, 8'h01};
    vecs[2] = '{4'b0011, 3'd7, 32'hD4C3_B2A1, 4'b0001, 4'b0001, 8'h80};
    vecs[3] = '{4'b1001, 3'd5, 32'h9C8B_7A69, 4'b1000, 4'b0001, 8'h20};
    vecs[4] = '{4'b1100, 3'd2, 32'h5E4D_3C2B, 4'b0100, 4'b0100, 8'h04};
    vecs[5] = '{4'b0101, 3'd6, 32'hF0E1_D2C3, 4'b0001, 4'b0001, 8'h40};
    order_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rstn = 1'b0;
    bus.req = '0; bus.clr_req = 1'b0; bus.addr = '0; bus.data = '0;
    do_reset();

    // Reset values
    check("rst_gnt",      64'(bus.gnt),      64'(0));
    check("rst_ack",      64'(bus.ack),      64'(0));
    check("rst_clr_ack",  64'(bus.clr_ack),  64'(0));
    check("rst_lat_en",   64'(bus.lat_en),   64'(0));
    check("rst_lat_d",    64'(bus.lat_d),    64'(0));
    check("rst_busy",     64'(bus.busy),     64'(0));
    check("rst_lat_rstn", 64'(bus.lat_rstn), 64'(1));

    // Table: single write first, then arbitration patterns
    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Fairness with all requesters continuously re-requesting
    do_reset();
    bus.addr = {NREQ{3'd4}};
    bus.data = 32'h4433_2211;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = order_rr[k];
`endif
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 20);
      check("fair_gnt", 64'(bus.gnt), 64'(exp_g));
      n = 0;
      do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 20);
      check("fair_ack", 64'(bus.ack), 64'(exp_g));
      bus.req = (k == 4) ? '0 : (bus.req & ~bus.ack);
      @(negedge clk);
      if (k != 4) bus.req = 4'b1111;
    end

    // Clear wins over a simultaneous write request
    bus.clr_req = 1'b1;
    bus.req     = 4'b0100;
    bus.addr    = {NREQ{3'd2}};
    bus.data    = 32'h005A_0000;
    @(negedge clk);
    check("clr_lat_rstn", 64'(bus.lat_rstn), 64'(0));
    check("clr_ack",      64'(bus.clr_ack),  64'(1));
    check("clr_gnt",      64'(bus.gnt),      64'(0));
    bus.clr_req = 1'b0;
    @(negedge clk);
    check("clr_idle_rstn", 64'(bus.lat_rstn), 64'(1));
    check("clr_idle_ack",  64'(bus.clr_ack),  64'(0));
    check("clr_idle_busy", 64'(bus.busy),     64'(0));
    @(negedge clk);
    check("clr_then_gnt", 64'(bus.gnt),   64'(4'b0100));
    check("clr_then_d",   64'(bus.lat_d), 64'(8'h5A));
    repeat (EN_CYC) @(negedge clk);
    @(negedge clk);
    check("clr_then_ack", 64'(bus.ack), 64'(4'b0100));
    bus.req = '0;
    @(negedge clk);

    // Inputs frozen after the IDLE sample; early req drop still completes
    bus.req  = 4'b0100;
    bus.addr = {NREQ{3'd1}};
    bus.data = 32'h0011_0000;
    @(negedge clk);
    check("frz_setup_d", 64'(bus.lat_d), 64'(8'h11));
    @(negedge clk);
    check("frz_en1", 64'(bus.lat_en), 64'(8'h02));
    bus.data = 32'hFFFF_FFFF;
    bus.addr = {NREQ{3'd6}};
    bus.req  = '0;
    @(negedge clk);
    check("frz_en2",   64'(bus.lat_en), 64'(8'h02));
    check("frz_en2_d", 64'(bus.lat_d),  64'(8'h11));
    @(negedge clk);
    check("frz_ack",    64'(bus.ack),   64'(4'b0100));
    check("frz_hold_d", 64'(bus.lat_d), 64'(8'h11));
    @(negedge clk);
    check("frz_idle_busy", 64'(bus.busy), 64'(0));

    // Reset in the middle of ENABLE
    bus.req  = 4'b0001;
    bus.addr = {NREQ{3'd1}};
    bus.data = 32'h0000_0077;
    @(negedge clk);
    @(negedge clk);
    check("mid_en", 64'(bus.lat_en), 64'(8'h02));
    rstn    = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check("mid_rst_en",   64'(bus.lat_en),   64'(0));
    check("mid_rst_gnt",  64'(bus.gnt),      64'(0));
    check("mid_rst_busy", 64'(bus.busy),     64'(0));
    check("mid_rst_d",    64'(bus.lat_d),    64'(0));
    check("mid_rst_rstn", 64'(bus.lat_rstn), 64'(1));
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | (bus.ack != '0);
    end
    check("mid_rst_no_ack", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
